// File: rtl/shell_pkg.sv
// Shared types and geometry helpers for the multi-slot shell overlay.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shell_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_LEFT  = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLY   = 2'd1,
        BLAST = 2'd2
    } slot_st_e;

    // VGA timing, colour and mouse bundle carried through the pipeline.
    typedef struct packed {
        logic        hblnk;
        logic        vblnk;
        logic        hsync;
        logic        vsync;
        logic [10:0] hcount;
        logic [9:0]  vcount;
        logic [11:0] rgb;
        logic [11:0] xpos_m;
        logic [11:0] ypos_m;
    } vga_t;

    // True when p lies within c +/- h. The lower bound is clipped at 0 so a
    // box near the screen edge never wraps onto the far side.
    function automatic logic in_span(input logic signed [12:0] p,
                                     input logic signed [12:0] c,
                                     input logic signed [12:0] h);
        logic signed [12:0] lo;
        logic signed [12:0] hi;
        lo = c - h;
        if (lo < 13'sd0) begin
            lo = 13'sd0;
        end
        hi = c + h;
        return (p >= lo) && (p <= hi);
    endfunction

    function automatic logic in_box(input logic signed [12:0] px,
                                    input logic signed [12:0] py,
                                    input logic signed [12:0] cx,
                                    input logic signed [12:0] cy,
                                    input logic signed [12:0] hx,
                                    input logic signed [12:0] hy);
        return in_span(px, cx, hx) && in_span(py, cy, hy);
    endfunction

endpackage

// File: rtl/shell_slot.sv
// One shell slot: flight/blast FSM, blast frame counter and registered pixel test.
// Latency: pix_on/pix_color are 1 cycle behind hcount/vcount.
// Backpressure: none; free-running pixel stream.
module shell_slot
    import shell_pkg::*;
#(
    parameter int          HALF_LEN      = 5,
    parameter int          HALF_WID      = 2,
    parameter int          MUZZLE_OFF    = 24,
    parameter int          BLAST_HALF    = 6,
    parameter int          BLAST_FRAMES  = 8,
    parameter logic [11:0] SHELL_COLOR   = 12'h000,
    parameter logic [11:0] BLAST_COLOR_A = 12'hF80,
    parameter logic [11:0] BLAST_COLOR_B = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  xpos,
    input  logic [9:0]  ypos,
    input  logic [2:0]  dir_in,
    input  logic        tank_hit,
    input  logic        obstacle_hit,
    input  logic        vs_edge,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic        pix_on,
    output logic [11:0] pix_color,
    output logic        fly,
    output logic        blast
);

    localparam logic signed [12:0] MUZ  = 13'(MUZZLE_OFF);
    localparam logic signed [12:0] HL   = 13'(HALF_LEN);
    localparam logic signed [12:0] HW   = 13'(HALF_WID);
    localparam logic signed [12:0] BH   = 13'(BLAST_HALF);
    localparam logic [7:0]         CNT0 = 8'(BLAST_FRAMES - 1);

    slot_st_e           state_q, state_d;
    logic [2:0]         dir_q, dir_d;
    logic signed [12:0] bx_q, bx_d;
    logic signed [12:0] by_q, by_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               pix_on_q, pix_on_d;
    logic [11:0]        pix_color_q, pix_color_d;

    logic signed [12:0] cx, cy, px, py;
    logic               vertical;

    // Live shell box centre from the current bullet position and latched direction.
    always_comb begin
        cx = $signed({3'b000, xpos});
        cy = $signed({3'b000, ypos});
        if (dir_q == DIR_DOWN) begin
            cy = cy + MUZ;
        end
        if (dir_q == DIR_RIGHT) begin
            cx = cx + MUZ;
        end
        px       = $signed({2'b00, hcount});
        py       = $signed({3'b000, vcount});
        vertical = (dir_q == DIR_UP) || (dir_q == DIR_DOWN);
    end

    // Slot FSM next-state: launch, hit/abort in flight, blast countdown on vsync edges.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        bx_d    = bx_q;
        by_d    = by_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if ((dir_in >= DIR_UP) && (dir_in <= DIR_LEFT)) begin
                    state_d = FLY;
                    dir_d   = dir_in;
                end
            end
            FLY: begin
                // A hit outranks a simultaneous abort.
                if (tank_hit || obstacle_hit) begin
                    state_d = BLAST;
                    bx_d    = cx;
                    by_d    = cy;
                    cnt_d   = CNT0;
                end else if (dir_in == DIR_NONE) begin
                    state_d = IDLE;
                end
            end
            BLAST: begin
                if (vs_edge) begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage-1 pixel test against the shell or blast box of the current state.
    always_comb begin
        pix_on_d    = 1'b0;
        pix_color_d = SHELL_COLOR;
        case (state_q)
            FLY: begin
                if (vertical) begin
                    pix_on_d = in_box(px, py, cx, cy, HW, HL);
                end else begin
                    pix_on_d = in_box(px, py, cx, cy, HL, HW);
                end
            end
            BLAST: begin
                pix_on_d    = in_box(px, py, bx_q, by_q, BH, BH);
                pix_color_d = cnt_q[0] ? BLAST_COLOR_B : BLAST_COLOR_A;
            end
            default: pix_on_d = 1'b0;
        endcase
    end

    // Slot state and stage-1 pixel registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dir_q       <= 3'd0;
            bx_q        <= 13'sd0;
            by_q        <= 13'sd0;
            cnt_q       <= 8'd0;
            pix_on_q    <= 1'b0;
            pix_color_q <= 12'h000;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            cnt_q       <= cnt_d;
            pix_on_q    <= pix_on_d;
            pix_color_q <= pix_color_d;
        end
    end

    assign pix_on    = pix_on_q;
    assign pix_color = pix_color_q;
    assign fly       = (state_q == FLY);
    assign blast     = (state_q == BLAST);

endmodule

// File: rtl/shell_renderer_multi.sv
// Overlays up to NUM_SHELLS shells/blasts on the VGA stream; lowest slot index wins.
// Latency: every *_out is exactly 2 pixel clocks behind its input.
// Backpressure: none; free-running pixel stream.
module shell_renderer_multi
    import shell_pkg::*;
#(
    parameter int          NUM_SHELLS    = 4,
    parameter int          HALF_LEN      = 5,
    parameter int          HALF_WID      = 2,
    parameter int          MUZZLE_OFF    = 24,
    parameter int          BLAST_HALF    = 6,
    parameter int          BLAST_FRAMES  = 8,
    parameter logic [11:0] SHELL_COLOR   = 12'h000,
    parameter logic [11:0] BLAST_COLOR_A = 12'hF80,
    parameter logic [11:0] BLAST_COLOR_B = 12'hFF0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [10*NUM_SHELLS-1:0] xpos_bullet,
    input  logic [10*NUM_SHELLS-1:0] ypos_bullet,
    input  logic [3*NUM_SHELLS-1:0]  direction,
    input  logic [NUM_SHELLS-1:0]    tank_hit,
    input  logic [NUM_SHELLS-1:0]    obstacle_hit,
    input  logic                    hblnk,
    input  logic                    vblnk,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic [10:0]             hcount,
    input  logic [9:0]              vcount,
    input  logic [11:0]             rgb,
    input  logic [11:0]             xpos_m,
    input  logic [11:0]             ypos_m,
    output logic                    hblnk_out,
    output logic                    vblnk_out,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic [10:0]             hcount_out,
    output logic [9:0]              vcount_out,
    output logic [11:0]             rgb_out,
    output logic [11:0]             xpos_m_out,
    output logic [11:0]             ypos_m_out,
    output logic [NUM_SHELLS-1:0]   shell_active,
    output logic [NUM_SHELLS-1:0]   blast_active
);

    vga_t        s1_q, s1_d, s2_q, s2_d;
    logic        vsync_q, vsync_d;
    logic        vs_edge;
    logic [NUM_SHELLS-1:0] pix_on;
    logic [11:0] pix_color [NUM_SHELLS];
    logic [11:0] rgb_mux;

    assign vs_edge = vsync & ~vsync_q;

    for (genvar g = 0; g < NUM_SHELLS; g++) begin : g_slot
        shell_slot #(
            .HALF_LEN      (HALF_LEN),
            .HALF_WID      (HALF_WID),
            .MUZZLE_OFF    (MUZZLE_OFF),
            .BLAST_HALF    (BLAST_HALF),
            .BLAST_FRAMES  (BLAST_FRAMES),
            .SHELL_COLOR   (SHELL_COLOR),
            .BLAST_COLOR_A (BLAST_COLOR_A),
            .BLAST_COLOR_B (BLAST_COLOR_B)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .xpos         (xpos_bullet[10*g +: 10]),
            .ypos         (ypos_bullet[10*g +: 10]),
            .dir_in       (direction[3*g +: 3]),
            .tank_hit     (tank_hit[g]),
            .obstacle_hit (obstacle_hit[g]),
            .vs_edge      (vs_edge),
            .hcount       (hcount),
            .vcount       (vcount),
            .pix_on       (pix_on[g]),
            .pix_color    (pix_color[g]),
            .fly          (shell_active[g]),
            .blast        (blast_active[g])
        );
    end

    // Stage-1 capture of timing/colour/mouse, and vsync history for edge detect.
    always_comb begin
        s1_d.hblnk  = hblnk;
        s1_d.vblnk  = vblnk;
        s1_d.hsync  = hsync;
        s1_d.vsync  = vsync;
        s1_d.hcount = hcount;
        s1_d.vcount = vcount;
        s1_d.rgb    = rgb;
        s1_d.xpos_m = xpos_m;
        s1_d.ypos_m = ypos_m;
        vsync_d     = vsync;
    end

    // Stage-2 priority mux: scanning high to low leaves the lowest active slot on top.
    always_comb begin
        rgb_mux = s1_q.rgb;
        for (int i = NUM_SHELLS - 1; i >= 0; i--) begin
            if (pix_on[i]) begin
                rgb_mux = pix_color[i];
            end
        end
        s2_d     = s1_q;
        s2_d.rgb = rgb_mux;
    end

    // Two-stage pipeline registers and vsync delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            vsync_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            vsync_q <= vsync_d;
        end
    end

    assign hblnk_out  = s2_q.hblnk;
    assign vblnk_out  = s2_q.vblnk;
    assign hsync_out  = s2_q.hsync;
    assign vsync_out  = s2_q.vsync;
    assign hcount_out = s2_q.hcount;
    assign vcount_out = s2_q.vcount;
    assign rgb_out    = s2_q.rgb;
    assign xpos_m_out = s2_q.xpos_m;
    assign ypos_m_out = s2_q.ypos_m;

endmodule
